// File: rtl/fix_add_pipe.sv
// Two-stage pipelined signed fixed-point adder/subtractor with valid/ready on both sides.
// Optional accumulator mode when FIX_ADD_ACC_EN is defined (adds in_acc/in_clr ports).
module fix_add_pipe #(
    parameter int WIDTH = 32,
    parameter bit SAT   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
`ifdef FIX_ADD_ACC_EN
    input  logic             in_acc,
    input  logic             in_clr,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ovf
);

    // Handshake: a beat moves on a rising edge only while its valid and the
    // receiving side's ready are both high; held data stays stable until then.
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic             s1_sub_q, s1_sub_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_sum_q, s2_sum_d;
    logic             s2_ovf_q, s2_ovf_d;
`ifdef FIX_ADD_ACC_EN
    logic             s1_acc_q, s1_acc_d;
    logic             s1_clr_q, s1_clr_d;
    logic [WIDTH-1:0] acc_q, acc_d;
`endif

    logic             s1_load;
    logic             s2_load;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   a_ext;
    logic [WIDTH:0]   b_ext;
    logic [WIDTH:0]   full;
    logic             ovf;
    logic [WIDTH-1:0] result;

    always_comb begin
        s2_load  = !s2_valid_q || out_ready;
        s1_load  = !s1_valid_q || s2_load;
        in_ready = s1_load;

        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_sub_d   = s1_sub_q;
`ifdef FIX_ADD_ACC_EN
        s1_acc_d   = s1_acc_q;
        s1_clr_d   = s1_clr_q;
`endif
        if (s1_load) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_a_d   = in_a;
                s1_b_d   = in_b;
                s1_sub_d = in_sub;
`ifdef FIX_ADD_ACC_EN
                s1_acc_d = in_acc;
                s1_clr_d = in_clr;
`endif
            end
        end

        // Accumulator operand is picked at S2-load time so chained acc beats see the latest value.
        b_eff = s1_b_q;
`ifdef FIX_ADD_ACC_EN
        if (s1_acc_q) begin
            b_eff = s1_clr_q ? '0 : acc_q;
        end
`endif
        a_ext = {s1_a_q[WIDTH-1], s1_a_q};
        b_ext = {b_eff[WIDTH-1], b_eff};
        full  = s1_sub_q ? (a_ext - b_ext) : (a_ext + b_ext);
        ovf   = full[WIDTH] ^ full[WIDTH-1];

        if (SAT && ovf) begin
            result = full[WIDTH] ? MIN_NEG : MAX_POS;
        end else begin
            result = full[WIDTH-1:0];
        end

        s2_valid_d = s2_valid_q;
        s2_sum_d   = s2_sum_q;
        s2_ovf_d   = s2_ovf_q;
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_sum_d = result;
                s2_ovf_d = ovf;
            end
        end

`ifdef FIX_ADD_ACC_EN
        acc_d = acc_q;
        if (s2_load && s1_valid_q && s1_acc_q) begin
            acc_d = result;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_sub_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_sum_q   <= '0;
            s2_ovf_q   <= 1'b0;
`ifdef FIX_ADD_ACC_EN
            s1_acc_q   <= 1'b0;
            s1_clr_q   <= 1'b0;
            acc_q      <= '0;
`endif
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_sub_q   <= s1_sub_d;
            s2_valid_q <= s2_valid_d;
            s2_sum_q   <= s2_sum_d;
            s2_ovf_q   <= s2_ovf_d;
`ifdef FIX_ADD_ACC_EN
            s1_acc_q   <= s1_acc_d;
            s1_clr_q   <= s1_clr_d;
            acc_q      <= acc_d;
`endif
        end
    end

    assign out_valid = s2_valid_q;
    assign out_sum   = s2_sum_q;
    assign out_ovf   = s2_ovf_q;

endmodule

// File: tb/tb_fix_add_pipe.sv
// Directed bench for fix_add_pipe: a saturating and a wrapping instance share stimulus,
// and a scoreboard checks every accepted result in order.
module tb_fix_add_pipe;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_sub = 1'b0;
    logic         in_acc = 1'b0;
    logic         in_clr = 1'b0;
    logic         out_ready = 1'b1;
    logic         in_ready, out_valid, out_ovf;
    logic [W-1:0] out_sum;
    logic         w_in_ready, w_out_valid, w_out_ovf;
    logic [W-1:0] w_out_sum;

    logic [W:0]   exp_q[$];
    logic [W:0]   wexp_q[$];
    int           n_vec = 0;
    int           n_err = 0;
    int           n_out = 0;
    bit           mon_en = 1'b1;

    fix_add_pipe #(.WIDTH(W), .SAT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
`ifdef FIX_ADD_ACC_EN
        .in_acc(in_acc), .in_clr(in_clr),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf)
    );

    fix_add_pipe #(.WIDTH(W), .SAT(1'b0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
`ifdef FIX_ADD_ACC_EN
        .in_acc(in_acc), .in_clr(in_clr),
`endif
        .out_valid(w_out_valid), .out_ready(out_ready), .out_sum(w_out_sum), .out_ovf(w_out_ovf)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // scoreboard: outputs sampled mid-cycle, transfer happens on the next rising edge
    always @(negedge clk) begin
        if (rst_n && mon_en && out_valid && out_ready) begin
            n_out++;
            check("wrap_valid", w_out_valid, 1'b1);
            if (exp_q.size() == 0) begin
                check("unexpected_out", 1'b1, 1'b0);
            end else begin
                logic [W:0] e;
                logic [W:0] we;
                e  = exp_q.pop_front();
                we = wexp_q.pop_front();
                check("sum", out_sum, e[W-1:0]);
                check("ovf", out_ovf, e[W]);
                check("w_sum", w_out_sum, we[W-1:0]);
                check("w_ovf", w_out_ovf, we[W]);
            end
        end
    end

    // driver: called at posedge+1, returns at posedge+1 after the accepting edge
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input logic acc, input logic clr,
                        input logic [W-1:0] es, input logic eo,
                        input logic [W-1:0] ews, input logic ewo);
        bit done;
        exp_q.push_back({eo, es});
        wexp_q.push_back({ewo, ews});
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_sub = sub;
        in_acc = acc;
        in_clr = clr;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        if (!done) check("in_ready_timeout", 1'b0, 1'b1);
        in_valid = 1'b0;
        in_acc = 1'b0;
        in_clr = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("drain", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    logic [W-1:0] bp_a[6] = '{32'd1, 32'd11, 32'd21, 32'd31, 32'd41, 32'd51};
    logic [W-1:0] bp_b[6] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    logic [W-1:0] bp_s[6] = '{32'd1, 32'd12, 32'd23, 32'd34, 32'd45, 32'd56};
    logic [3:0]   bub_pat;
    logic [7:0]   ov;

    initial begin
        // reset
        #2;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_sum", out_sum, 32'h0);
        check("rst_out_ovf", out_ovf, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // basic stream with latency and one-per-cycle checks
        send(32'd5, 32'd3, 1'b0, 1'b0, 1'b0, 32'd8, 1'b0, 32'd8, 1'b0);
        check("lat_s1_only", out_valid, 1'b0);
        send(32'd5, 32'd3, 1'b1, 1'b0, 1'b0, 32'd2, 1'b0, 32'd2, 1'b0);
        check("lat_first_valid", out_valid, 1'b1);
        check("lat_first_sum", out_sum, 32'd8);
        send(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFB, 1'b0, 32'hFFFF_FFFB, 1'b0);
        check("stream_second_sum", out_sum, 32'd2);
        @(posedge clk);
        #1;
        check("stream_third_sum", out_sum, 32'hFFFF_FFFB);
        drain();

        // saturation / wrap boundaries
        send(32'h7FFF_FFF0, 32'h20, 1'b0, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b1, 32'h8000_0010, 1'b1);
        send(32'h8000_0000, 32'h1, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 1'b1, 32'h7FFF_FFFF, 1'b1);
        send(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        send(32'h0, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b1, 32'h8000_0000, 1'b1);
        send(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b1, 32'hFFFF_FFFE, 1'b1);
        send(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 1'b1, 32'h7FFF_FFFF, 1'b1);
        drain();

        // backpressure: out_ready low for 5 cycles while both stages hold beats
        n_out = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send(bp_a[i], bp_b[i], 1'b0, 1'b0, 1'b0, bp_s[i], 1'b0, bp_s[i], 1'b0);
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("bp_in_ready", in_ready, 1'b0);
                    check("bp_hold_valid", out_valid, 1'b1);
                    check("bp_hold_sum", out_sum, 32'd12);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", n_out, 6);

        // bubbles: in_valid 1,0,1,0 must reappear on out_valid two cycles later
        bub_pat = 4'b0101;
        for (int i = 0; i < 8; i++) begin
            in_valid = (i < 4) ? bub_pat[i] : 1'b0;
            in_a = i;
            in_b = 32'd1;
            in_sub = 1'b0;
            if (in_valid) begin
                exp_q.push_back({1'b0, in_a + 32'd1});
                wexp_q.push_back({1'b0, in_a + 32'd1});
            end
            @(negedge clk);
            ov[i] = out_valid;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("bub_lead0", ov[0], 1'b0);
        check("bub_lead1", ov[1], 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("bub_pattern", ov[i+2], bub_pat[i]);
        end
        drain();

        // asynchronous reset mid-stream
        mon_en = 1'b0;
        in_valid = 1'b1;
        in_a = 32'd100;
        in_b = 32'd1;
        in_sub = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #3;
        check("pre_rst_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 1'b0);
        check("async_rst_sum", out_sum, 32'h0);
        check("async_rst_ovf", out_ovf, 1'b0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        wexp_q.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_quiet", out_valid, 1'b0);
        end
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        send(32'd7, 32'd8, 1'b0, 1'b0, 1'b0, 32'd15, 1'b0, 32'd15, 1'b0);
        check("post_rst_lat_s1", out_valid, 1'b0);
        @(posedge clk);
        #1;
        check("post_rst_lat_valid", out_valid, 1'b1);
        check("post_rst_lat_sum", out_sum, 32'd15);
        drain();

`ifdef FIX_ADD_ACC_EN
        // accumulator chaining and saturation
        send(32'd1, 32'd0, 1'b0, 1'b1, 1'b1, 32'd1, 1'b0, 32'd1, 1'b0);
        send(32'd2, 32'd0, 1'b0, 1'b1, 1'b0, 32'd3, 1'b0, 32'd3, 1'b0);
        send(32'd3, 32'd0, 1'b0, 1'b1, 1'b0, 32'd6, 1'b0, 32'd6, 1'b0);
        send(32'h7FFF_FFFF, 32'd0, 1'b0, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b0);
        send(32'd1, 32'd0, 1'b0, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 32'h8000_0000, 1'b1);
        drain();
`endif

        check("final_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
